// File: rtl/mod_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mod_ctrl_pkg                                                        |
// | Shared definitions for the repeated-subtraction modulo controller: |
// | FSM state encodings, datapath control encodings, default limits.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package mod_ctrl_pkg;

   // FSM state encoding (IDLE, LOAD, RUN, DONE)
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_RUN  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Datapath control encodings, packed as {s, we}
   localparam logic [1:0] DP_HOLD = 2'b10;
   localparam logic [1:0] DP_LOAD = 2'b00;
   localparam logic [1:0] DP_SUB  = 2'b01;

   // Default subtraction-cycle limit
   localparam logic [31:0] MAX_ITER_DEFAULT = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/mod_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mod_ctrl_if                                                         |
// | Bundles the issue handshake and the datapath control/status lines  |
// | of the modulo controller. The quotient port exists only when       |
// | MOD_QUOTIENT_EN is defined.                                        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface mod_ctrl_if #(
   parameter int WIDTH = 32
);
   // issue side
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] result;
`ifdef MOD_QUOTIENT_EN
   logic [WIDTH-1:0] quotient;
`endif
   // datapath side
   logic             dp_s;
   logic             dp_we;
   logic [WIDTH-1:0] dp_a;
   logic [WIDTH-1:0] dp_b;
   logic             dp_x;
   logic [WIDTH-1:0] dp_result;

   // controller view
   modport slave (
      input  start, a, b, dp_x, dp_result,
      output busy, done, err, result, dp_s, dp_we, dp_a, dp_b
`ifdef MOD_QUOTIENT_EN
      , output quotient
`endif
   );

   // issue logic plus datapath view
   modport master (
      output start, a, b, dp_x, dp_result,
      input  busy, done, err, result, dp_s, dp_we, dp_a, dp_b
`ifdef MOD_QUOTIENT_EN
      , input quotient
`endif
   );
endinterface
`default_nettype wire

// File: rtl/mod_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mod_controller                                                      |
// | Sequences the shared-subtractor modulo datapath: validates the     |
// | operands, loads the dividend, subtracts until the datapath flags   |
// | temp < b, then returns a mod b with a one-cycle done pulse.        |
// | Optional feature macro: MOD_QUOTIENT_EN (adds quotient output).    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mod_controller
   import mod_ctrl_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] MAX_ITER = WIDTH'(MAX_ITER_DEFAULT)
)(
   input  logic      CLK,
   input  logic      RST,
   mod_ctrl_if.slave ctrl_if
);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] dp_a_q,   dp_a_d;
   logic [WIDTH-1:0] dp_b_q,   dp_b_d;
   logic [WIDTH-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q,    err_d;
   logic [1:0]       dp_ctrl;
   logic             reject;
`ifdef MOD_QUOTIENT_EN
   logic [WIDTH-1:0] quot_q,   quot_d;
`endif

   // Negative operands break the signed compare; a zero divisor never ends.
   assign reject = (ctrl_if.b == '0) || ctrl_if.a[WIDTH-1] || ctrl_if.b[WIDTH-1];

   // Next-state, operand capture, iteration limit and result update
   always_comb begin
      state_d  = state_q;
      dp_a_d   = dp_a_q;
      dp_b_d   = dp_b_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
`ifdef MOD_QUOTIENT_EN
      quot_d   = quot_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ctrl_if.start) begin
               dp_a_d = ctrl_if.a;
               dp_b_d = ctrl_if.b;
               cnt_d  = '0;
               if (reject) begin
                  state_d  = ST_DONE;
                  err_d    = 1'b1;
                  result_d = '0;
`ifdef MOD_QUOTIENT_EN
                  quot_d   = '0;
`endif
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            if (ctrl_if.dp_x) begin
               state_d  = ST_DONE;
               err_d    = 1'b0;
               result_d = ctrl_if.dp_result;
`ifdef MOD_QUOTIENT_EN
               quot_d   = cnt_q;
`endif
            end else if (cnt_q == MAX_ITER - 1'b1) begin
               // limit checked before incrementing so the counter never wraps
               state_d  = ST_DONE;
               err_d    = 1'b1;
               result_d = '0;
`ifdef MOD_QUOTIENT_EN
               quot_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and data registers, cleared asynchronously
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         dp_a_q   <= '0;
         dp_b_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
`ifdef MOD_QUOTIENT_EN
         quot_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         dp_a_q   <= dp_a_d;
         dp_b_q   <= dp_b_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef MOD_QUOTIENT_EN
         quot_q   <= quot_d;
`endif
      end
   end

   // Datapath control decode from the current state
   always_comb begin
      dp_ctrl = DP_HOLD;
      case (state_q)
         ST_LOAD: dp_ctrl = DP_LOAD;
         ST_RUN:  dp_ctrl = DP_SUB;
         default: dp_ctrl = DP_HOLD;
      endcase
   end

   assign {ctrl_if.dp_s, ctrl_if.dp_we} = dp_ctrl;
   assign ctrl_if.busy   = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign ctrl_if.done   = (state_q == ST_DONE);
   assign ctrl_if.err    = err_q;
   assign ctrl_if.result = result_q;
   assign ctrl_if.dp_a   = dp_a_q;
   assign ctrl_if.dp_b   = dp_b_q;
`ifdef MOD_QUOTIENT_EN
   assign ctrl_if.quotient = quot_q;
`endif

endmodule
`default_nettype wire

// File: doc/mod_controller.md
# mod_controller

Sequencing controller for the team's 32-bit repeated-subtraction modulo datapath, which uses a shared subtractor and signed set-less-than. It accepts a start/operand handshake and validates the operands. It drives the datapath's `s`/`we` controls until the datapath raises `x`, then returns `a mod b` with a one-cycle `done` pulse. It sits between the ALU issue logic and the datapath, and owns all control of the datapath.

## Interface
- `WIDTH`, 32: operand/result width; must match the datapath.
- `MAX_ITER`, 32'hFFFF_FFFF: subtraction-cycle limit; reaching it aborts with `err`.

- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `a` in WIDTH: dividend, sampled with `start`.
- `b` in WIDTH: divisor, sampled with `start`.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: one-cycle completion pulse (DONE state).
- `err` out 1: valid with `done`; operand rejected or iteration limit hit.
- `result` out WIDTH: `a mod b`; holds until the next accepted start.
- `dp_s` out 1: datapath `s` control.
- `dp_we` out 1: datapath `we` control.
- `dp_a` out WIDTH: registered operand to the datapath.
- `dp_b` out WIDTH: registered operand to the datapath.
- `dp_x` in 1: datapath completion (combinational, high when temp < b, signed).
- `dp_result` in WIDTH: datapath result, valid while `dp_x` is high.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - Outputs: `dp_s`=1, `dp_we`=0 (datapath hold).
  - On `start`, capture `a`/`b` into `dp_a`/`dp_b` and clear the iteration counter.
  - If `b`==0, `a[31]` or `b[31]`: next state is DONE with `err`=1, `result`=0. The signed compare gives wrong moduli for negative operands, and `b`==0 never terminates.
  - Otherwise next state is LOAD.
- **LOAD**: `dp_s`=0, `dp_we`=0. The datapath latches `dp_a` at the end of the cycle. Next state is RUN.
- **RUN**
  - Outputs: `dp_s`=0, `dp_we`=1.
  - If `dp_x`=1: register `dp_result` into `result`; next state is DONE with `err`=0.
  - Else if the counter equals `MAX_ITER`-1: next state is DONE with `err`=1, `result`=0.
  - Else: increment the counter.
- **DONE**: `done`=1, `dp_s`=1, `dp_we`=0. Next state is IDLE.
- `dp_a`/`dp_b` stay stable from acceptance through DONE, because the datapath uses `b` combinationally every cycle.
- `start` outside IDLE is ignored, with no queuing. A `start` held high re-triggers on the cycle after DONE.
- Counter is WIDTH bits and never wraps: the limit check precedes the increment.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `result`=0, `dp_s`=1, `dp_we`=0, `dp_a`=0, `dp_b`=0, counter 0; `quotient`=0 when enabled.
- `RST` mid-operation returns to IDLE immediately, and all outputs take their reset values asynchronously.
- Let the accepting edge be edge 0 and q = floor(a/b). LOAD runs edge 0→1, RUN edges 1→q+2, and `done` is high q+2 → q+3.
  - Total latency from accept to `done`: q+2 cycles.
- Rejected operands: `done` is high during the cycle after edge 0.
- `result`/`err` update on the same edge that enters DONE, and hold afterwards.

## Configuration
- `MOD_QUOTIENT_EN`
  - Defined: adds output port `quotient` (out, WIDTH bits) = counter value registered on entry to DONE. This equals floor(a/b) on success and 0 on `err`.
  - Undefined: no `quotient` port; the counter exists only for the `MAX_ITER` check. All other behaviour is identical.

## Structure
- Shared package `mod_ctrl_pkg`:
  - state enum (IDLE, LOAD, RUN, DONE);
  - encoding localparams for the datapath controls: HOLD {s=1,we=0}, LOAD {0,0}, SUB {0,1};
  - default `MAX_ITER`.
- No sub-module: FSM, operand registers and counter stay in one module.
- The bench instantiates the team's existing modulo datapath as the DUT partner.

## Test plan
- `a`=17, `b`=5, `start` for 1 cycle → `busy` for 5 cycles, `done` exactly q+2=5 cycles after accept; `result`=2, `err`=0, `quotient`=3.
- `a`=3, `b`=7 → `done` 2 cycles after accept; `result`=3, `quotient`=0.
- `a`=9, `b`=0, then separately `a`=32'h8000_0004, `b`=3 → `done` 1 cycle after accept; `err`=1, `result`=0, no LOAD/RUN control pattern.
- `MAX_ITER`=4, `a`=100, `b`=1 → `err`=1 after exactly 4 RUN cycles; `done` pulses once.
- Assert `RST` during RUN of `a`=1000, `b`=3 → all outputs at reset values within the cycle. A following request with `a`=10, `b`=4 yields `result`=2.
- `start` held high across two requests (20 mod 6, then 8 mod 8) → second request accepted the cycle after DONE; results 2 and 0. `start` pulses during `busy` are ignored.
